// File: rtl/vc_credit_tx_pkg.sv
// Shared definitions for the VC credit transmitter.
//   credit_width(depth) : counter width able to hold 0..depth
//   onehot(idx)         : MAX_VC-wide one-hot vector with bit idx set;
//                         callers cast it down to their own width
package vc_credit_tx_pkg;

    localparam int MAX_VC = 32;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [MAX_VC-1:0] onehot(input int idx);
        return MAX_VC'(1) << idx;
    endfunction

endpackage

// File: rtl/vc_credit_tx_rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst     : clock, asynchronous active-low reset
//   req[N]       : request vector
//   grant[N]     : combinational one-hot grant (zero when no request)
//   grant_valid  : any request granted this cycle
//   grant_idx    : binary index of the granted requester
// The scan starts at ptr; ptr moves one past the winner on a grant and
// holds otherwise.
module rr_arbiter
    import vc_credit_tx_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    int            cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
        grant = grant_valid ? N'(onehot(int'(grant_idx))) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            if (grant_idx == IW'(N - 1)) ptr <= '0;
            else                         ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vc_credit_tx.sv
// Transmit side of a credit-flow-controlled output link.
//   clk, rst      : clock, asynchronous active-low reset
//   src_valid[VC] : local VC i has a head flit
//   src_data      : head flits, VC i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_pop[VC]   : one-hot pop of the granted local VC (combinational)
//   credit_ret[VC]: downstream freed one slot of VC i
//   link_valid    : registered flit-present strobe
//   link_data     : registered flit (holds when link idle)
//   link_vc       : registered one-hot destination VC, zero when idle
//   credit_avail  : per-VC credit non-zero
//   credit_err    : sticky, a credit came back to an already-full counter
module vc_credit_tx
    import vc_credit_tx_pkg::*;
#(
    parameter int VC         = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VC-1:0]            src_valid,
    input  logic [VC*DATA_WIDTH-1:0] src_data,
    output logic [VC-1:0]            src_pop,
    input  logic [VC-1:0]            credit_ret,
    output logic                     link_valid,
    output logic [DATA_WIDTH-1:0]    link_data,
    output logic [VC-1:0]            link_vc,
    output logic [VC-1:0]            credit_avail,
    output logic                     credit_err
);

    localparam int CREDIT_W = credit_width(FIFO_DEPTH);
    localparam int IW       = (VC > 1) ? $clog2(VC) : 1;
    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(FIFO_DEPTH);

    logic [CREDIT_W-1:0] credit [VC];
    logic [VC-1:0]       eligible;
    logic [VC-1:0]       grant;
    logic                grant_valid;
    logic [IW-1:0]       grant_idx;

    for (genvar i = 0; i < VC; i++) begin : g_avail
        assign credit_avail[i] = (credit[i] != '0);
    end

    // Eligibility uses the registered credit only, so a credit returned this
    // cycle can enable a grant no earlier than the next cycle.
    assign eligible = src_valid & credit_avail;
    assign src_pop  = grant;

    rr_arbiter #(.N(VC)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (eligible),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A simultaneous grant and return on one VC cancel out; a lone return to
    // a full counter is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VC; i++) credit[i] <= FULL;
            credit_err <= 1'b0;
        end else begin
            for (int i = 0; i < VC; i++) begin
                case ({grant[i], credit_ret[i]})
                    2'b10: credit[i] <= credit[i] - 1'b1;
                    2'b01: begin
                        if (credit[i] == FULL) credit_err <= 1'b1;
                        else                   credit[i]  <= credit[i] + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_valid <= 1'b0;
            link_vc    <= '0;
            link_data  <= '0;
        end else begin
            link_valid <= grant_valid;
            link_vc    <= grant;
            if (grant_valid)
                link_data <= src_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_vc_credit_tx.sv
module tb_vc_credit_tx;

    localparam int NV  = 4;
    localparam int DW  = 32;
    localparam int DEP = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NV-1:0]    src_valid;
    logic [NV*DW-1:0] src_data;
    logic [NV-1:0]    src_pop;
    logic [NV-1:0]    credit_ret;
    logic             link_valid;
    logic [DW-1:0]    link_data;
    logic [NV-1:0]    link_vc;
    logic [NV-1:0]    credit_avail;
    logic             credit_err;

    vc_credit_tx #(.VC(NV), .DATA_WIDTH(DW), .FIFO_DEPTH(DEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_pop      (src_pop),
        .credit_ret   (credit_ret),
        .link_valid   (link_valid),
        .link_data    (link_data),
        .link_vc      (link_vc),
        .credit_avail (credit_avail),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [NV-1:0] vc;
    } exp_t;

    typedef struct {
        logic [NV-1:0] v;
        logic [NV-1:0] r;
        logic [NV-1:0] pop;
    } vec_t;

    exp_t          sb[$];
    int            tests  = 0;
    int            failed = 0;
    int            m_credit [NV];
    int            m_ptr;
    bit            m_err;
    logic [DW-1:0] m_last;
    logic [NV-1:0] last_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) m_credit[i] = DEP;
        m_ptr  = 0;
        m_err  = 1'b0;
        m_last = '0;
        sb.delete();
    endtask

    // Drive one cycle of inputs, check the combinational pop, then check the
    // registered link one edge later against the scoreboard.
    task automatic step(input logic [NV-1:0] v, input logic [NV-1:0] r, input logic [NV*DW-1:0] d);
        int   g;
        exp_t e;
        logic [NV-1:0] ep;
        src_valid  = v;
        credit_ret = r;
        src_data   = d;
        #1;
        g = -1;
        for (int k = 0; k < NV; k++) begin
            int j;
            j = (m_ptr + k) % NV;
            if (g < 0 && v[j] && m_credit[j] > 0) g = j;
        end
        ep = (g >= 0) ? NV'(1 << g) : '0;
        last_pop = src_pop;
        chk("src_pop", 32'(src_pop), 32'(ep));
        if (g >= 0) sb.push_back('{1'b1, d[g*DW +: DW], ep});
        else        sb.push_back('{1'b0, '0, '0});
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            bit dec, inc;
            dec = (i == g);
            inc = r[i];
            if (dec && !inc) m_credit[i]--;
            else if (inc && !dec) begin
                if (m_credit[i] == DEP) m_err = 1'b1;
                else                    m_credit[i]++;
            end
        end
        if (g >= 0) m_ptr = (g + 1) % NV;
        e = sb.pop_front();
        if (e.valid) m_last = e.data;
        chk("link_valid", 32'(link_valid), 32'(e.valid));
        chk("link_vc", 32'(link_vc), 32'(e.vc));
        chk("link_data", link_data, m_last);
        for (int i = 0; i < NV; i++)
            chk("credit_avail", 32'(credit_avail[i]), 32'(m_credit[i] != 0));
        chk("credit_err", 32'(credit_err), 32'(m_err));
    endtask

    function automatic logic [NV*DW-1:0] rnd_data();
        logic [NV*DW-1:0] d;
        for (int i = 0; i < NV; i++) d[i*DW +: DW] = $urandom;
        return d;
    endfunction

    // Asserts reset between edges, checks the asynchronous clear, releases
    // it after the next edge.
    task automatic do_reset();
        rst = 1'b0;
        src_valid  = '0;
        credit_ret = '0;
        #2;
        model_reset();
        chk("rst_link_valid", 32'(link_valid), 32'd0);
        chk("rst_link_vc", 32'(link_vc), 32'd0);
        chk("rst_link_data", link_data, 32'd0);
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        chk("rst_credit_avail", 32'(credit_avail), 32'hF);
        chk("rst_src_pop", 32'(src_pop), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [11];
        int   pops;
        logic [NV*DW-1:0] d;

        rst        = 1'b0;
        src_valid  = '0;
        credit_ret = '0;
        src_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single flit on VC0
        d = rnd_data();
        d[DW-1:0] = 32'hA5;
        step(4'b0001, 4'b0000, d);
        chk("a5_pop", 32'(last_pop), 32'b0001);
        chk("a5_link_data", link_data, 32'hA5);
        chk("a5_link_vc", 32'(link_vc), 32'b0001);
        chk("a5_credit0", 32'(dut.credit[0]), 32'd31);

        // ptr is 1 after the single grant above
        vt[0]  = '{4'b0000, 4'b0000, 4'b0000};
        vt[1]  = '{4'b1111, 4'b0000, 4'b0010};
        vt[2]  = '{4'b1111, 4'b0000, 4'b0100};
        vt[3]  = '{4'b1111, 4'b0000, 4'b1000};
        vt[4]  = '{4'b1111, 4'b0000, 4'b0001};
        vt[5]  = '{4'b1111, 4'b0001, 4'b0010};
        vt[6]  = '{4'b0011, 4'b0000, 4'b0001};
        vt[7]  = '{4'b1001, 4'b0000, 4'b1000};
        vt[8]  = '{4'b1001, 4'b0000, 4'b0001};
        vt[9]  = '{4'b0100, 4'b0010, 4'b0100};
        vt[10] = '{4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 11; i++) begin
            step(vt[i].v, vt[i].r, rnd_data());
            chk($sformatf("vec%0d_pop", i), 32'(last_pop), 32'(vt[i].pop));
        end

        // drain VC2 completely, then return a credit
        do_reset();
        pops = 0;
        for (int i = 0; i < 33; i++) begin
            step(4'b0100, 4'b0000, rnd_data());
            if (last_pop == 4'b0100) pops++;
        end
        chk("vc2_flits", 32'(pops), 32'd32);
        chk("vc2_avail", 32'(credit_avail[2]), 32'd0);
        chk("vc2_pop33", 32'(last_pop), 32'd0);
        step(4'b0100, 4'b0100, rnd_data());
        chk("vc2_ret_same_cycle", 32'(last_pop), 32'd0);
        step(4'b0100, 4'b0000, rnd_data());
        chk("vc2_ret_next_cycle", 32'(last_pop), 32'b0100);
        chk("vc2_ret_link_vc", 32'(link_vc), 32'b0100);

        // grant and return together at credit 10
        do_reset();
        for (int i = 0; i < 22; i++) step(4'b0001, 4'b0000, rnd_data());
        chk("vc0_credit10", 32'(dut.credit[0]), 32'd10);
        step(4'b0001, 4'b0001, rnd_data());
        chk("vc0_cancel_pop", 32'(last_pop), 32'b0001);
        chk("vc0_cancel_credit", 32'(dut.credit[0]), 32'd10);

        // grant+return at full credit is not an error; a lone return is
        do_reset();
        step(4'b0010, 4'b0010, rnd_data());
        chk("full_cancel_err", 32'(credit_err), 32'd0);
        chk("full_cancel_credit", 32'(dut.credit[1]), 32'd32);
        step(4'b0000, 4'b0100, rnd_data());
        chk("overflow_err", 32'(credit_err), 32'd1);
        chk("overflow_credit", 32'(dut.credit[2]), 32'd32);
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, rnd_data());
        chk("err_sticky", 32'(credit_err), 32'd1);

        // reset with a flit in flight
        src_valid = 4'b1111;
        src_data  = rnd_data();
        #1;
        do_reset();
        chk("midrst_credit3", 32'(dut.credit[3]), 32'd32);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [NV-1:0] v, r;
            v = NV'($urandom_range(0, 15));
            r = ($urandom_range(0, 2) == 0) ? NV'($urandom_range(0, 15)) : '0;
            step(v, r, rnd_data());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
